// File: rtl/bram_pipe.sv
// Single-port block RAM with byte write enables, selectable read-during-write
// behaviour and a fixed-latency read pipeline that tags every response with a valid strobe.
module bram_pipe #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 15,
  parameter int DEPTH   = 2**ADDR_W,
  parameter int RD_LAT  = 2,
  parameter int WR_MODE = 0,
  parameter int BE_W    = DATA_W/8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              ren,
  input  logic              wen,
  input  logic [BE_W-1:0]   be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              addr_err
);

  localparam int              IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L     = (ADDR_W+1)'(DEPTH);
  localparam bit              WRITE_FIRST = (WR_MODE == 1);
  localparam bit              NO_CHANGE   = (WR_MODE == 2);

  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BE_W-1:0]   mask
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < BE_W; i++)
      if (mask[i]) res[8*i +: 8] = new_w[8*i +: 8];
    return res;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              rd_go;
  logic              err_go;
  logic              wr_go;
  logic [DATA_W-1:0] rd_raw;
  logic [DATA_W-1:0] rd_data;

  logic [DATA_W-1:0] data_p [RD_LAT];
  logic [RD_LAT-1:0] vld_p;
  logic [RD_LAT-1:0] err_p;

  assign idx      = addr[IDX_W-1:0];
  assign in_range = ({1'b0, addr} < DEPTH_L);
  assign rd_go    = en & ren & ~(wen & NO_CHANGE);
  assign err_go   = en & (ren | wen) & ~in_range;
  // rst_n gates the array write so an edge inside reset never commits data
  assign wr_go    = rst_n & en & wen & in_range;

  always_comb begin
    rd_raw  = '0;
    rd_data = '0;
    if (in_range) begin
      rd_raw  = mem[idx];
      rd_data = (wen && WRITE_FIRST) ? byte_merge(rd_raw, din, be) : rd_raw;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_go)
      for (int i = 0; i < BE_W; i++)
        if (be[i]) mem[idx][8*i +: 8] <= din[8*i +: 8];
  end

  // stage p0 captures the array at the issuing edge; later stages only shift
  always_ff @(posedge clk) begin
    data_p[0] <= rd_data;
    for (int s = 1; s < RD_LAT; s++)
      data_p[s] <= data_p[s-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p    <= '0;
      err_p    <= '0;
      dout     <= '0;
      dout_vld <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      vld_p[0] <= rd_go;
      err_p[0] <= err_go;
      for (int s = 1; s < RD_LAT; s++) begin
        vld_p[s] <= vld_p[s-1];
        err_p[s] <= err_p[s-1];
      end
      // output stage: dout only moves when a real response arrives
      dout_vld <= vld_p[RD_LAT-1];
      addr_err <= err_p[RD_LAT-1];
      if (vld_p[RD_LAT-1]) dout <= data_p[RD_LAT-1];
    end
  end

endmodule

// File: tb/tb_bram_pipe.sv
// Bench for bram_pipe: five instances with different latency, mode, depth and width
// share one stimulus stream; a per-instance cycle scoreboard predicts every output cycle.
module tb_bram_pipe;

  localparam int ND = 5;
  localparam int          LAT   [ND] = '{2, 1, 3, 4, 2};
  localparam int          MODE  [ND] = '{0, 1, 2, 0, 0};
  localparam int          DEP   [ND] = '{1000, 1024, 1024, 1024, 32768};
  localparam logic [31:0] DMASK [ND] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                         32'hFFFF_FFFF, 32'h0000_00FF};

  typedef struct packed {
    logic        vld;
    logic        err;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [3:0]  be = '0;
  logic [14:0] addr = '0;
  logic [31:0] din = '0;

  logic [31:0] dout_w [ND];
  logic        vld_w  [ND];
  logic        err_w  [ND];
  logic [7:0]  dout4;

  logic [31:0] mm [ND][1024];
  ent_t        sb [ND][$];
  logic [31:0] last_dout [ND];

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  bram_pipe #(.DATA_W(32), .ADDR_W(10), .DEPTH(1000), .RD_LAT(2), .WR_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .ren(ren), .wen(wen), .be(be), .addr(addr[9:0]),
    .din(din), .dout(dout_w[0]), .dout_vld(vld_w[0]), .addr_err(err_w[0]));
  bram_pipe #(.DATA_W(32), .ADDR_W(10), .RD_LAT(1), .WR_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .ren(ren), .wen(wen), .be(be), .addr(addr[9:0]),
    .din(din), .dout(dout_w[1]), .dout_vld(vld_w[1]), .addr_err(err_w[1]));
  bram_pipe #(.DATA_W(32), .ADDR_W(10), .RD_LAT(3), .WR_MODE(2)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .ren(ren), .wen(wen), .be(be), .addr(addr[9:0]),
    .din(din), .dout(dout_w[2]), .dout_vld(vld_w[2]), .addr_err(err_w[2]));
  bram_pipe #(.DATA_W(32), .ADDR_W(10), .RD_LAT(4), .WR_MODE(0)) u3 (
    .clk(clk), .rst_n(rst_n), .en(en), .ren(ren), .wen(wen), .be(be), .addr(addr[9:0]),
    .din(din), .dout(dout_w[3]), .dout_vld(vld_w[3]), .addr_err(err_w[3]));
  bram_pipe u4 (
    .clk(clk), .rst_n(rst_n), .en(en), .ren(ren), .wen(wen), .be(be[0:0]), .addr(addr),
    .din(din[7:0]), .dout(dout4), .dout_vld(vld_w[4]), .addr_err(err_w[4]));

  assign dout_w[4] = {24'h0, dout4};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  // Drive one cycle of stimulus (called at a falling edge), predict, then compare.
  task automatic op(input logic e, input logic r, input logic w, input logic [3:0] b,
                    input logic [14:0] a, input logic [31:0] d);
    ent_t        ent;
    logic [31:0] old;
    logic [31:0] mrg;
    bit          inr;
    en = e; ren = r; wen = w; be = b; addr = a; din = d;
    for (int k = 0; k < ND; k++) begin
      if (!rst_n) begin
        sb[k].delete();
        last_dout[k] = '0;
        continue;
      end
      inr = int'(a) < DEP[k];
      old = mm[k][a[9:0]];
      mrg = old;
      for (int i = 0; i < 4; i++)
        if (b[i]) mrg[8*i +: 8] = d[8*i +: 8];
      ent.vld  = e && r && !(w && MODE[k] == 2);
      ent.err  = e && (r || w) && !inr;
      ent.data = !inr ? 32'h0 : ((w && MODE[k] == 1) ? mrg : old);
      ent.data = ent.data & DMASK[k];
      if (e && w && inr) mm[k][a[9:0]] = mrg;
      sb[k].push_back(ent);
    end
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      if (sb[k].size() > LAT[k]) ent = sb[k].pop_front();
      else ent = '0;
      if (ent.vld) last_dout[k] = ent.data;
      check($sformatf("u%0d.dout_vld", k), {31'h0, vld_w[k]}, {31'h0, ent.vld});
      check($sformatf("u%0d.addr_err", k), {31'h0, err_w[k]}, {31'h0, ent.err});
      check($sformatf("u%0d.dout", k), dout_w[k], last_dout[k]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 1'b0, 1'b0, 4'h0, 15'd0, 32'h0);
  endtask

  // Assert reset asynchronously, keep trying to write addr 5 while it is held.
  task automatic do_reset(input int cyc);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < ND; k++) begin
      sb[k].delete();
      last_dout[k] = '0;
      check($sformatf("u%0d.rst_vld", k), {31'h0, vld_w[k]}, 32'h0);
      check($sformatf("u%0d.rst_err", k), {31'h0, err_w[k]}, 32'h0);
      check($sformatf("u%0d.rst_dout", k), dout_w[k], 32'h0);
    end
    for (int i = 0; i < cyc; i++) op(1'b1, 1'b0, 1'b1, 4'hF, 15'd5, 32'hDEAD_BEEF);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < ND; k++) last_dout[k] = '0;
    #2;
    do_reset(2);

    // first op right after release, then a read of the just-written word
    op(1, 0, 1, 4'hF, 15'd11, 32'h0000_0005);
    op(1, 1, 0, 4'h0, 15'd11, 32'h0);
    idle(5);

    // preload 0..7 then stream them back; en=0 must mask ren/wen afterwards
    for (int i = 0; i < 8; i++) op(1, 0, 1, 4'hF, 15'(i), 32'h10 + 32'(i));
    for (int i = 0; i < 8; i++) op(1, 1, 0, 4'h0, 15'(i), 32'h0);
    for (int i = 0; i < 6; i++) op(0, 1, 1, 4'hF, 15'd2, 32'hFFFF_FFFF);

    // read-during-write with partial byte enables, then a follow-up read
    op(1, 0, 1, 4'hF, 15'd3, 32'hAABB_CCDD);
    op(1, 1, 1, 4'b0101, 15'd3, 32'h1122_3344);
    op(1, 1, 0, 4'h0, 15'd3, 32'h0);
    op(1, 0, 1, 4'h0, 15'd3, 32'hFFFF_FFFF);
    op(1, 1, 0, 4'h0, 15'd3, 32'h0);
    idle(5);

    // out-of-range traffic (only u0 has DEPTH=1000)
    op(1, 0, 1, 4'hF, 15'd1000, 32'h5A5A_5A5A);
    op(1, 0, 1, 4'hF, 15'd1023, 32'h3C3C_3C3C);
    op(1, 1, 0, 4'h0, 15'd1000, 32'h0);
    op(1, 0, 1, 4'hF, 15'd1023, 32'h0000_00FF);
    op(1, 1, 0, 4'h0, 15'd1023, 32'h0);
    op(1, 1, 0, 4'h0, 15'd999, 32'h0);
    idle(5);

    // reset while three reads are in flight
    op(1, 1, 0, 4'h0, 15'd0, 32'h0);
    op(1, 1, 0, 4'h0, 15'd1, 32'h0);
    op(1, 1, 0, 4'h0, 15'd2, 32'h0);
    do_reset(2);
    idle(6);
    op(1, 1, 0, 4'h0, 15'd5, 32'h0);
    op(1, 1, 0, 4'h0, 15'd7, 32'h0);
    idle(5);

    // write->read on consecutive edges, then a random mix
    op(1, 0, 1, 4'hF, 15'd20, 32'hCAFE_F00D);
    op(1, 1, 0, 4'h0, 15'd20, 32'h0);
    for (int i = 0; i < 16; i++) op(1, 0, 1, 4'hF, 15'(i), $urandom);
    for (int i = 0; i < 80; i++) begin
      logic [14:0] a;
      case ($urandom_range(0, 9))
        0:       a = 15'd1000;
        1:       a = 15'd1023;
        default: a = 15'($urandom_range(0, 15));
      endcase
      op(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
         logic'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom);
    end
    idle(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
